// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: two-requester writeback arbiter for the register-file write port.
// Optional build macro REGFILE_ARB_R0_DISCARD_EN suppresses writes to r0.
`default_nettype none

module regfile_wr_arb #(
    parameter int DW         = 16,
    parameter int AW         = 3,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          a_valid_i,
    input  logic [AW-1:0] a_wr_i,
    input  logic [DW-1:0] a_wd_i,
    output logic          a_ready_o,
    input  logic          b_valid_i,
    input  logic [AW-1:0] b_wr_i,
    input  logic [DW-1:0] b_wd_i,
    output logic          b_ready_o,
    output logic          rf_en_o,
    output logic [AW-1:0] rf_wr_o,
    output logic [DW-1:0] rf_wd_o,
    output logic [AW-1:0] pend_wr_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]    starve_q, starve_d;
    logic          rf_en_q;
    logic [AW-1:0] rf_wr_q;
    logic [DW-1:0] rf_wd_q;

    logic          grant_a, grant_b, write_d;
    logic [AW-1:0] win_wr;
    logic [DW-1:0] win_wd;

    // A wins unless B has been starved for STARVE_MAX consecutive cycles.
    assign grant_a = a_valid_i & (~b_valid_i | (starve_q != STARVE_LIM));
    assign grant_b = b_valid_i & ~grant_a;

    assign win_wr = grant_b ? b_wr_i : a_wr_i;
    assign win_wd = grant_b ? b_wd_i : a_wd_i;

`ifdef REGFILE_ARB_R0_DISCARD_EN
    // r0 writes are still handshaken and still count as grants, but never reach the file.
    assign write_d = (grant_a | grant_b) & (win_wr != '0);
`else
    assign write_d = grant_a | grant_b;
`endif

    always_comb begin
        starve_d = starve_q;
        if (!b_valid_i || grant_b) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            starve_q <= 4'd0;
            rf_en_q  <= 1'b0;
            rf_wr_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            starve_q <= starve_d;
            rf_en_q  <= write_d;
            if (write_d) begin
                rf_wr_q <= win_wr;
                rf_wd_q <= win_wd;
            end
        end
    end

    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;
    assign rf_en_o   = rf_en_q;
    assign rf_wr_o   = rf_wr_q;
    assign rf_wd_o   = rf_wd_q;
    assign pend_wr_o = rf_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: scoreboard bench for regfile_wr_arb.
`default_nettype none

module tb_regfile_wr_arb;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_valid, b_valid, a_ready, b_ready, rf_en;
    logic [AW-1:0] a_wr, b_wr, rf_wr, pend_wr;
    logic [DW-1:0] a_wd, b_wd, rf_wd;

    always #5 clk = ~clk;

    regfile_wr_arb #(.DW(DW), .AW(AW), .STARVE_MAX(SM)) dut (
        .clk_i     (clk),
        .reset_ni  (reset_n),
        .a_valid_i (a_valid),
        .a_wr_i    (a_wr),
        .a_wd_i    (a_wd),
        .a_ready_o (a_ready),
        .b_valid_i (b_valid),
        .b_wr_i    (b_wr),
        .b_wd_i    (b_wd),
        .b_ready_o (b_ready),
        .rf_en_o   (rf_en),
        .rf_wr_o   (rf_wr),
        .rf_wd_o   (rf_wd),
        .pend_wr_o (pend_wr)
    );

    typedef struct packed {
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
    } wr_t;

    wr_t sb_q[$];
    int  m_starve = 0;
    int  n_chk    = 0;
    int  n_err    = 0;
    int  wins[5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns 0 = no grant, 1 = A, 2 = B.
    task automatic cycle(input logic av, input logic [AW-1:0] aw, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] bw, input logic [DW-1:0] bd,
                         output int win);
        wr_t e;
        a_valid = av; a_wr = aw; a_wd = ad;
        b_valid = bv; b_wr = bw; b_wd = bd;
        #1;
        if (av && bv) win = (m_starve >= SM) ? 2 : 1;
        else if (av)  win = 1;
        else if (bv)  win = 2;
        else          win = 0;
        check("a_ready", 32'(a_ready), 32'(win == 1));
        check("b_ready", 32'(b_ready), 32'(win == 2));
        if (win != 0) begin
            e.wr = (win == 1) ? aw : bw;
            e.wd = (win == 1) ? ad : bd;
`ifdef REGFILE_ARB_R0_DISCARD_EN
            if (e.wr != '0) sb_q.push_back(e);
`else
            sb_q.push_back(e);
`endif
        end
        if (bv && win != 2) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
        else                m_starve = 0;
        @(posedge clk); #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rf_en", 32'(rf_en), 32'd1);
            check("rf_wr", 32'(rf_wr), 32'(e.wr));
            check("rf_wd", 32'(rf_wd), 32'(e.wd));
            check("pend_wr", 32'(pend_wr), 32'(e.wr));
        end else begin
            check("rf_en_idle", 32'(rf_en), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int w;
        reset_n = 1'b0;
        a_valid = 1'b0; a_wr = '0; a_wd = '0;
        b_valid = 1'b0; b_wr = '0; b_wd = '0;
        #12;
        check("rst_rf_en", 32'(rf_en), 32'd0);
        check("rst_rf_wr", 32'(rf_wr), 32'd0);
        check("rst_rf_wd", 32'(rf_wd), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        cycle(0, 0, 0, 0, 0, 0, w);
        cycle(0, 0, 0, 0, 0, 0, w);

        // A only
        cycle(1, 3'd3, 16'h1234, 0, 0, 0, w);
        check("a_only_win", 32'(w), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, w);

        // B alone
        cycle(0, 0, 0, 1, 3'd7, 16'hBEEF, w);
        check("b_only_win", 32'(w), 32'd2);
        cycle(0, 0, 0, 0, 0, 0, w);

        // Contention, both held
        for (int i = 0; i < 5; i++) begin
            cycle(1, 3'd5, 16'hAAAA, 1, 3'd6, 16'h5555, w);
            wins[i] = w;
        end
        check("cont_c1", 32'(wins[0]), 32'd1);
        check("cont_c3", 32'(wins[2]), 32'd1);
        check("cont_c4", 32'(wins[3]), 32'd2);
        check("cont_c5", 32'(wins[4]), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, w);

        // Same destination: B must eventually write last
        cycle(1, 3'd2, 16'h1111, 1, 3'd2, 16'h2222, w);
        cycle(0, 0, 0, 1, 3'd2, 16'h2222, w);
        check("same_dst_b", 32'(w), 32'd2);
        cycle(0, 0, 0, 0, 0, 0, w);

        // Back-to-back A writes
        cycle(1, 3'd1, 16'h0001, 0, 0, 0, w);
        cycle(1, 3'd2, 16'h0002, 0, 0, 0, w);
        cycle(1, 3'd4, 16'h0004, 0, 0, 0, w);
        cycle(0, 0, 0, 0, 0, 0, w);

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), w);
        end
        cycle(0, 0, 0, 0, 0, 0, w);

        // r0 write
        cycle(1, 3'd0, 16'hFFFF, 0, 0, 0, w);
        check("r0_ready", 32'(w), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, w);

        // Asynchronous reset while a write is in flight
        a_valid = 1'b1; a_wr = 3'd5; a_wd = 16'hCAFE;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("pre_rst_en", 32'(rf_en), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_en", 32'(rf_en), 32'd0);
        check("async_rst_wr", 32'(rf_wr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.delete();
        m_starve = 0;
        cycle(0, 0, 0, 0, 0, 0, w);
        cycle(0, 0, 0, 0, 0, 0, w);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
